// File: rtl/imem_loader_pkg.sv
// Shared constants for the boot loader: FSM encoding and default frame marker.
package imem_loader_pkg;

    // Loader FSM states, in frame order.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // Default start-of-frame marker.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/imem_loader.sv
// Boot-time program loader: parses a framed byte stream, writes the payload
// byte-by-byte into instruction memory, verifies an XOR checksum and holds the
// core in reset until a verified image is in place.
//
// Handshake: a byte transfers on a rising edge where rx_valid && rx_ready.
// rx_ready depends only on the current state (never on rx_valid), so the
// sender may hold rx_valid/rx_data until it sees the transfer edge.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  reload,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  core_rst_n,
    output logic                  done,
    output logic                  error,
    output state_t                fsm_state
);

    // Largest image in 32-bit words that fits the byte-addressed memory.
    localparam int unsigned MAX_WORDS = (2 ** ADDR_WIDTH) / 4;
    // Width of a byte index derived from a 16-bit word count.
    localparam int unsigned IDX_W     = 18;

    state_t                state_q;
    state_t                state_d;
    logic [7:0]            len_hi_q;
    logic [15:0]           len_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [7:0]            chk_q;

    logic                  accept;
    logic                  reload_take;
    logic [15:0]           len_word;
    logic [IDX_W-1:0]      last_idx;
    logic                  last_byte;

    // Ready in every frame-parsing state; closed in DONE/ERR and during reset.
    assign rx_ready    = !reset && (state_q inside {ST_IDLE, ST_LEN_HI, ST_LEN_LO,
                                                    ST_DATA, ST_CHECK});
    assign accept      = rx_valid && rx_ready;
    assign reload_take = reload && (state_q inside {ST_DONE, ST_ERR});

    // Full word count as it arrives with the low byte.
    assign len_word  = {len_hi_q, rx_data};
    // Index of the final payload byte; only consulted in DATA where LEN >= 1.
    assign last_idx  = {len_q, 2'b00} - IDX_W'(1);
    assign last_byte = (IDX_W'(cnt_q) == last_idx);

    assign fsm_state = state_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every transition needs an accepted byte, except reload.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && (rx_data == SYNC_BYTE)) state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (accept) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (accept) begin
                    if (len_word > 16'(MAX_WORDS)) begin
                        state_d = ST_ERR;
                    end else if (len_word == 16'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept && last_byte) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (accept) state_d = (rx_data == chk_q) ? ST_DONE : ST_ERR;
            end
            ST_DONE, ST_ERR: begin
                if (reload) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame datapath: length capture, byte counter, running checksum and the
    // one-stage memory write pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_hi_q  <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            chk_q     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                unique case (state_q)
                    ST_LEN_HI: begin
                        len_hi_q <= rx_data;
                    end
                    ST_LEN_LO: begin
                        len_q <= len_word;
                        cnt_q <= '0;
                        chk_q <= '0;
                    end
                    ST_DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= cnt_q;
                        mem_wdata <= rx_data;
                        chk_q     <= chk_q ^ rx_data;
                        // The last byte leaves the counter parked, so it never wraps.
                        if (!last_byte) cnt_q <= cnt_q + 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            if (reload_take) begin
                cnt_q <= '0;
                chk_q <= '0;
            end
        end
    end

    // Status outputs follow the next state so they switch on the transition edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done       <= 1'b0;
            error      <= 1'b0;
            core_rst_n <= 1'b0;
        end else begin
            done       <= (state_d == ST_DONE);
            error      <= (state_d == ST_ERR);
            core_rst_n <= (state_d == ST_DONE);
        end
    end

endmodule
